// File: rtl/motor_command_ramp.sv
// motor_command_ramp: per-frame slew limiter and command watchdog driving a motor PWM width
// Ports:
//   clk_255kHz, reset    clock and synchronous active-high reset
//   target_i[7:0]        commanded width (0 = 1 ms, 255 = 2 ms)
//   target_load_i        strobe: latch target_i (ignored while paused), clear watchdog
//   pause_i              level: ramp to NEUTRAL and hold while high
//   width_out_o[7:0]     ramped width to the PWM generator
//   frame_tick_o         one-cycle pulse per frame
//   state_o[1:0]         0 IDLE, 1 RUN, 2 PAUSED, 3 FAILSAFE
//   at_target_o          width_out_o equals the effective target
// Define MOTOR_RAMP_SNAP_FAILSAFE_EN to jump straight to NEUTRAL on frames in PAUSED/FAILSAFE.
module motor_command_ramp #(
  parameter int         STEP           = 4,
  parameter int         FRAME_TICKS    = 5100,
  parameter int         TIMEOUT_FRAMES = 25,
  parameter logic [7:0] NEUTRAL        = 8'd127
) (
  input  logic       clk_255kHz,
  input  logic       reset,
  input  logic [7:0] target_i,
  input  logic       target_load_i,
  input  logic       pause_i,
  output logic [7:0] width_out_o,
  output logic       frame_tick_o,
  output logic [1:0] state_o,
  output logic       at_target_o
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, FAILSAFE} state_t;
  localparam int CW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  localparam int WW = $clog2(TIMEOUT_FRAMES + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    tgt_q, tgt_d, width_q, width_d, eff, ramp;
  logic [8:0]    diff, mag;
  logic          tick_q, tick_d;
  always_comb begin
    eff = state_q == RUN ? tgt_q : NEUTRAL;
    // magnitude of the 9-bit difference decides between landing on eff and a full step
    diff = {1'b0, eff} - {1'b0, width_q};
    mag = diff[8] ? -diff : diff;
    ramp = mag <= 9'(STEP) ? eff : diff[8] ? width_q - 8'(STEP) : width_q + 8'(STEP);
`ifdef MOTOR_RAMP_SNAP_FAILSAFE_EN
    width_d = !tick_q ? width_q : (state_q == PAUSED || state_q == FAILSAFE) ? NEUTRAL : ramp;
`else
    width_d = tick_q ? ramp : width_q;
`endif
    cnt_d = cnt_q == CW'(FRAME_TICKS - 1) ? '0 : cnt_q + 1'b1;
    tick_d = cnt_q == CW'(FRAME_TICKS - 1);
    wd_d = target_load_i ? '0 : (tick_q && wd_q != WW'(TIMEOUT_FRAMES)) ? wd_q + 1'b1 : wd_q;
    tgt_d = target_load_i && state_q != PAUSED ? target_i : tgt_q;
    state_d = pause_i ? PAUSED :
              state_q == PAUSED ? IDLE :
              (state_q == IDLE || state_q == FAILSAFE) && target_load_i ? RUN :
              state_q == RUN && wd_q == WW'(TIMEOUT_FRAMES) && !target_load_i ? FAILSAFE :
              state_q;
  end
  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tick_q <= 1'b0;
      wd_q <= '0;
      tgt_q <= NEUTRAL;
      width_q <= NEUTRAL;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tick_q <= tick_d;
      wd_q <= wd_d;
      tgt_q <= tgt_d;
      width_q <= width_d;
    end
  end
  assign width_out_o = width_q;
  assign frame_tick_o = tick_q;
  assign state_o = state_q;
  assign at_target_o = width_q == eff;
endmodule

// File: tb/tb_motor_command_ramp.sv
// tb_motor_command_ramp: scoreboard bench for motor_command_ramp with short frames
module tb_motor_command_ramp;
  localparam int FT = 10;
  localparam int TO = 5;
`ifdef MOTOR_RAMP_SNAP_FAILSAFE_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_FAIL = 2'd3;
  typedef struct packed {logic [7:0] w; logic [1:0] s;} exp_t;
  logic       clk = 1'b0, reset = 1'b1, target_load = 1'b0, pause = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] width_out;
  logic       frame_tick, at_target;
  logic [1:0] state;
  exp_t       q[$];
  exp_t       e;
  int         checks = 0, errors = 0, frames = 0, gap = 0;
  bit         tick_prev = 1'b0, have_last = 1'b0;
  motor_command_ramp #(.STEP(4), .FRAME_TICKS(FT), .TIMEOUT_FRAMES(TO), .NEUTRAL(8'd127)) dut (
    .clk_255kHz(clk), .reset(reset), .target_i(target), .target_load_i(target_load),
    .pause_i(pause), .width_out_o(width_out), .frame_tick_o(frame_tick),
    .state_o(state), .at_target_o(at_target));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // monitor: one step per frame, compared just after the width update edge
  always @(posedge clk) begin
    #1;
    gap++;
    if (reset) begin
      tick_prev = 1'b0;
      have_last = 1'b0;
    end else begin
      if (tick_prev) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("frame_width", width_out, e.w);
          chk("frame_state", state, e.s);
        end
        frames++;
      end
      if (frame_tick) begin
        if (have_last) chk("tick_spacing", gap, FT);
        have_last = 1'b1;
        gap = 0;
      end
      tick_prev = frame_tick;
    end
  end
  task automatic frame(input bit ld, input bit co, input logic [7:0] t, input int ew, input logic [1:0] es);
    int f0 = frames;
    int n = 0;
    exp_t x;
    x.w = 8'(ew);
    x.s = es;
    q.push_back(x);
    if (ld && !co) begin
      target = t;
      target_load = 1'b1;
      @(negedge clk);
      target_load = 1'b0;
    end
    if (co) begin
      while (!frame_tick && n < 3 * FT) begin @(negedge clk); n++; end
      target = t;
      target_load = 1'b1;
      @(negedge clk);
      target_load = 1'b0;
    end
    while (frames == f0 && n < 3 * FT) begin @(negedge clk); n++; end
    if (frames == f0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_tick expected one within %0d cycles", 3 * FT);
    end
  endtask
  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_width", width_out, 127);
    chk("rst_state", state, S_IDLE);
    chk("rst_at_target", at_target, 1);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b0;
    frame(0, 0, 0, 127, S_IDLE);
    for (int k = 1; k <= 19; k++) begin
      frame(1, 0, 200, k < 19 ? 127 + 4 * k : 200, S_RUN);
      if (k == 10) chk("at_target_mid", at_target, 0);
    end
    chk("at_target_200", at_target, 1);
    for (int k = 1; k <= 14; k++) frame(1, 0, 255, k < 14 ? 200 + 4 * k : 255, S_RUN);
    for (int k = 1; k <= 64; k++) frame(1, 0, 0, k < 64 ? 255 - 4 * k : 0, S_RUN);
    for (int k = 1; k <= 4; k++) frame(0, 0, 0, 0, S_RUN);
    for (int k = 1; k <= 10; k++) frame(0, 0, 0, SNAP ? 127 : 4 * k, S_FAIL);
    w = SNAP ? 127 : 40;
    for (int k = 1; k <= 5; k++) frame(1, 0, 150, w + 4 * k, S_RUN);
    w = w + 20;
    for (int k = 1; k <= 30; k++) frame(1, 0, 200, w + 4 * k > 200 ? 200 : w + 4 * k, S_RUN);
    w = w + 120 > 200 ? 200 : w + 120;
    pause = 1'b1;
    for (int k = 1; k <= 5; k++) frame(k == 3, 0, 250, SNAP ? 127 : w - 4 * k, S_PAUSED);
    pause = 1'b0;
    for (int k = 1; k <= 2; k++) frame(0, 0, 0, SNAP ? 127 : w - 20 - 4 * k, S_IDLE);
    frame(1, 0, 240, SNAP ? 131 : 156, S_RUN);
    frame(1, 1, 100, SNAP ? 135 : 160, S_RUN);
    w = SNAP ? 135 : 160;
    for (int k = 1; k <= 5; k++) frame(0, 0, 0, w - 4 * k, S_RUN);
    frame(0, 0, 0, SNAP ? 127 : 136, S_FAIL);
    w = SNAP ? 127 : 136;
    do begin
      w = w + 4 > 200 ? 200 : w + 4;
      frame(1, 0, 200, w, S_RUN);
    end while (w != 200);
    chk("pre_reset_width", width_out, 200);
    reset = 1'b1;
    @(negedge clk);
    chk("midramp_reset_width", width_out, 127);
    chk("midramp_reset_state", state, S_IDLE);
    chk("midramp_reset_at_target", at_target, 1);
    chk("midramp_reset_tick", frame_tick, 0);
    reset = 1'b0;
    frame(0, 0, 0, 127, S_IDLE);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
